// File: rtl/vedic_pkg.sv
// rtl/vedic_pkg.sv - shared widths and types for the Vedic multiplier
package vedic_pkg;

  localparam int OPW = 8;
  localparam int PRW = 16;

  typedef logic [OPW-1:0] operand_t;
  typedef logic [PRW-1:0] product_t;

endpackage

// File: rtl/vedic_mult_4x4.sv
// rtl/vedic_mult_4x4.sv - combinational 4x4 Urdhva-Tiryagbhyam block
module vedic_mult_4x4
  import vedic_pkg::*;
(
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);

  // 2x2 cell: vertical terms give bits 0 and 3, crosswise terms meet in half adders
  function automatic logic [3:0] vedic_2x2(input logic [1:0] x, input logic [1:0] y);
    logic t1, t2, t3, c1;
    logic [3:0] p;
    t1   = x[1] & y[0];
    t2   = x[0] & y[1];
    t3   = x[1] & y[1];
    c1   = t1 & t2;
    p[0] = x[0] & y[0];
    p[1] = t1 ^ t2;
    p[2] = t3 ^ c1;
    p[3] = t3 & c1;
    return p;
  endfunction

  logic [3:0] w_ll;
  logic [3:0] w_hl;
  logic [3:0] w_lh;
  logic [3:0] w_hh;
  logic [5:0] w_mid;
  logic [5:0] w_upper;

  assign w_ll = vedic_2x2(i_a[1:0], i_b[1:0]);
  assign w_hl = vedic_2x2(i_a[3:2], i_b[1:0]);
  assign w_lh = vedic_2x2(i_a[1:0], i_b[3:2]);
  assign w_hh = vedic_2x2(i_a[3:2], i_b[3:2]);

  // Cross terms plus the carried-up half of LL, then HH shifted into place
  assign w_mid   = {2'b00, w_hl} + {2'b00, w_lh} + {4'b0000, w_ll[3:2]};
  assign w_upper = w_mid + {w_hh, 2'b00};

  assign o_p = {w_upper, w_ll[1:0]};

endmodule

// File: rtl/vedic_mult_8x8.sv
// rtl/vedic_mult_8x8.sv - 8x8 Vedic multiplier core with one registered output stage
module vedic_mult_8x8
  import vedic_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     in_valid,
  input  operand_t a,
  input  operand_t b,
  output product_t result,
  output logic     out_valid
);

  logic [7:0]  w_ll;
  logic [7:0]  w_hl;
  logic [7:0]  w_lh;
  logic [7:0]  w_hh;
  logic [11:0] w_mid;
  logic [11:0] w_upper;
  product_t    w_prod;

  product_t    r_result;
  logic        r_out_valid;

  vedic_mult_4x4 u_ll (.i_a(a[3:0]), .i_b(b[3:0]), .o_p(w_ll));
  vedic_mult_4x4 u_hl (.i_a(a[7:4]), .i_b(b[3:0]), .o_p(w_hl));
  vedic_mult_4x4 u_lh (.i_a(a[3:0]), .i_b(b[7:4]), .o_p(w_lh));
  vedic_mult_4x4 u_hh (.i_a(a[7:4]), .i_b(b[7:4]), .o_p(w_hh));

  // Worst case 225*16 + 225 + 225 + 14 = 4064 still fits the 12-bit upper sum
  assign w_mid   = {4'h0, w_hl} + {4'h0, w_lh} + {8'h00, w_ll[7:4]};
  assign w_upper = w_mid + {w_hh, 4'h0};
  assign w_prod  = {w_upper, w_ll[3:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_result    <= '0;
      r_out_valid <= 1'b0;
    end else if (in_valid) begin
      r_result    <= w_prod;
      r_out_valid <= 1'b1;
    end else begin
      r_out_valid <= 1'b0;
    end
  end

  assign result    = r_result;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_vedic_mult_8x8.sv
// tb/tb_vedic_mult_8x8.sv - self-checking bench for vedic_mult_8x8
module tb_vedic_mult_8x8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  a = 8'h00;
  logic [7:0]  b = 8'h00;
  logic [15:0] result;
  logic        out_valid;

  int checks = 0;
  int passes = 0;

  logic [15:0] exp_result = 16'h0000;
  logic        exp_valid  = 1'b0;

  vedic_mult_8x8 dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .result    (result),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
  endtask

  // Reference: a product appears one edge after a valid pair; reset wins; idle holds value
  task automatic step(input logic r, input logic v, input logic [7:0] x, input logic [7:0] y,
                      input string tag);
    @(negedge clk);
    rst = r; in_valid = v; a = x; b = y;
    @(posedge clk);
    if (r) begin
      exp_result = 16'h0000;
      exp_valid  = 1'b0;
    end else if (v) begin
      exp_result = 16'(int'(x) * int'(y));
      exp_valid  = 1'b1;
    end else begin
      exp_valid  = 1'b0;
    end
    #1;
    check({tag, ".result"}, result, exp_result);
    check({tag, ".out_valid"}, {15'd0, out_valid}, {15'd0, exp_valid});
  endtask

  initial begin
    step(1'b1, 1'b1, 8'd255, 8'd255, "reset0");
    step(1'b1, 1'b1, 8'd255, 8'd255, "reset1");
    check("reset_value", result, 16'h0000);

    step(1'b0, 1'b1, 8'd5,  8'd6,  "s0"); check("s0_const", result, 16'd30);
    step(1'b0, 1'b1, 8'd6,  8'd7,  "s1"); check("s1_const", result, 16'd42);
    step(1'b0, 1'b1, 8'd9,  8'd7,  "s2"); check("s2_const", result, 16'd63);
    step(1'b0, 1'b1, 8'd15, 8'd15, "s3"); check("s3_const", result, 16'd225);

    step(1'b0, 1'b1, 8'd30, 8'd30,  "c0"); check("c0_const", result, 16'd900);
    step(1'b0, 1'b1, 8'd0,  8'd0,   "c2"); check("c2_const", result, 16'd0);
    step(1'b0, 1'b1, 8'd1,  8'd255, "c3"); check("c3_const", result, 16'd255);
    step(1'b0, 1'b1, 8'd255, 8'd250, "m0"); check("m0_const", result, 16'd63750);
    step(1'b0, 1'b1, 8'd255, 8'd254, "m1"); check("m1_const", result, 16'd64770);
    step(1'b0, 1'b1, 8'd255, 8'd255, "m2"); check("m2_const", result, 16'hFE01);

    step(1'b0, 1'b1, 8'd25, 8'd25, "c1"); check("c1_const", result, 16'd625);
    step(1'b0, 1'b0, 8'd77, 8'd99, "hold0"); check("hold0_const", result, 16'd625);
    step(1'b0, 1'b0, 8'd12, 8'd34, "hold1"); check("hold1_const", result, 16'd625);

    step(1'b0, 1'b1, 8'd255, 8'd255, "pre_rst");
    step(1'b1, 1'b1, 8'd200, 8'd201, "mid_rst"); check("mid_rst_const", result, 16'h0000);
    step(1'b0, 1'b1, 8'd3, 8'd4, "post_rst"); check("post_rst_const", result, 16'd12);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] rnd;
      rnd = $urandom;
      step((rnd[3:0] == 4'd0), (rnd[5:4] != 2'd0), rnd[15:8], rnd[23:16], "rand");
    end

    for (int ai = 0; ai < 256; ai++) begin
      for (int bi = 0; bi < 256; bi++) begin
        step(1'b0, 1'b1, 8'(ai), 8'(bi), "exh");
      end
    end

    step(1'b0, 1'b0, 8'd0, 8'd0, "tail");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
